// File: rtl/muldiv_unit_pkg.sv
// Shared constants, state encoding and small helpers for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned STEPS = 32;

  localparam logic [5:0] R_FORM  = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // True for any R-form instruction that reads or writes HI/LO; the all-zero NOP never matches.
  function automatic logic is_hilo(input logic [XLEN-1:0] ins);
    logic hit;
    hit = 1'b0;
    if (ins != '0 && ins[31:26] == R_FORM) begin
      unique case (ins[5:0])
        F_MFHI, F_MTHI, F_MFLO, F_MTLO,
        F_MULT, F_MULTU, F_DIV, F_DIVU: hit = 1'b1;
        default:                        hit = 1'b0;
      endcase
    end
    return hit;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: 64-bit shift register, one shared 33-bit add/subtract, step counter.
module muldiv_core
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            op_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q;
  logic [4:0]        cnt_q;
  logic              op_div_q;

  logic [XLEN:0]     add_x, add_y;
  logic [XLEN+1:0]   sum;
  logic              q_bit;

  assign hi_o   = acc_q[2*XLEN-1:XLEN];
  assign lo_o   = acc_q[XLEN-1:0];
  assign done_o = step_i && (cnt_q == 5'(STEPS - 1));

  // Divide: subtract via ~y + 1, carry-out set means no borrow (quotient bit 1).
  // Multiply: add the multiplicand into HI when the multiplier LSB is set.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    add_x = op_div_q ? {hi_o, lo_o[XLEN-1]} : {1'b0, hi_o};
    add_y = op_div_q ? ~{1'b0, opnd_q} : ({(XLEN+1){lo_o[0]}} & {1'b0, opnd_q});
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, op_div_q};
    q_bit = sum[XLEN+1];
    acc_d = acc_q;
    if (op_div_q) begin
      acc_d = {(q_bit ? sum[XLEN-1:0] : add_x[XLEN-1:0]), lo_o[XLEN-2:0], q_bit};
    end else begin
      acc_d = {sum[XLEN:0], lo_o[XLEN-1:1]};
    end
  end

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
    end else if (start_i) begin
      acc_q    <= {{XLEN{1'b0}}, a_i};
      opnd_q   <= b_i;
      cnt_q    <= '0;
      op_div_q <= op_div_i;
    end else if (step_i) begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO unit: decode, IDLE/CALC/FIX control, sign fixup, HI/LO registers and stall generation.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            Valid,
  input  logic [XLEN-1:0] Ins,
  input  logic [XLEN-1:0] Rdata1,
  input  logic [XLEN-1:0] Rdata2,
  output logic [XLEN-1:0] HiLoOut,
  output logic            Busy,
  output logic            Stall,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            op_div_q, op_div_d;
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;
  logic            div0_q, div0_d;

  logic [5:0]      funct;
  logic            hilo, accept, is_md, signed_op, op_div, start;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            core_done;
  logic [XLEN-1:0] core_hi, core_lo;
  logic [2*XLEN-1:0] prod;

  assign funct     = Ins[5:0];
  assign hilo      = is_hilo(Ins);
  assign Busy      = (state_q != IDLE);
  assign Stall     = Busy && Valid && hilo;
  assign accept    = Valid && !Stall && hilo;
  assign is_md     = (funct[5:2] == 4'b0110);
  assign signed_op = (funct == F_MULT) || (funct == F_DIV);
  assign op_div    = funct[1];
  assign start     = accept && is_md;

  // Signed ops run on magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign sign_a = signed_op && Rdata1[XLEN-1];
  assign sign_b = signed_op && Rdata2[XLEN-1];
  assign mag_a  = neg_if(sign_a, Rdata1);
  assign mag_b  = neg_if(sign_b, Rdata2);

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign HiLoOut = (funct == F_MFHI) ? hi_q : lo_q;

  muldiv_core u_core (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start_i  (start),
    .step_i   (state_q == CALC),
    .op_div_i (op_div),
    .a_i      (mag_a),
    .b_i      (mag_b),
    .done_o   (core_done),
    .hi_o     (core_hi),
    .lo_o     (core_lo)
  );

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op_div_d = op_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    prod     = {core_hi, core_lo};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          op_div_d = op_div;
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = sign_a;
          div0_d   = op_div && (Rdata2 == '0);
        end else if (accept && funct == F_MTHI) begin
          hi_d = Rdata1;
        end else if (accept && funct == F_MTLO) begin
          lo_d = Rdata1;
        end
      end
      CALC: begin
        if (core_done) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (op_div_q) begin
          // With a zero divisor the core leaves |rs| in HI, so re-applying the dividend sign restores rs.
          lo_d = div0_q ? '1 : neg_if(neg_lo_q, core_lo);
          hi_d = neg_if(neg_hi_q, core_hi);
        end else begin
          if (neg_lo_q) prod = ~prod + 64'd1;
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      op_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      op_div_q <= op_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with the architectural HI/LO register pair, sitting in the execute stage directly downstream of ID. It consumes the decoded instruction and the two register-file read operands (rs, rt) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, which ID deliberately does not write back. For MFHI and MFLO it supplies the value that ID writes into the register file. While a multiply or divide is in flight it stalls any further HI/LO instruction.

## Interface
- No parameters. Operand width is fixed at 32; the iteration count is fixed at 32.
- CLK  in  1  — system clock, rising edge.
- RST_N  in  1  — asynchronous, active-low reset.
- Valid  in  1  — Ins/Rdata1/Rdata2 hold a live instruction this cycle.
- Ins  in  32  — current instruction; Opcode = Ins[31:26], Funct = Ins[5:0].
- Rdata1  in  32  — rs operand from ID.
- Rdata2  in  32  — rt operand from ID.
- HiLoOut  out  32  — HI when Funct == MFHI, otherwise LO; combinational from the registers; feeds the ID write-data mux.
- Busy  out  1  — a multiply/divide is in progress.
- Stall  out  1  — Busy && Valid && Ins is any HI/LO instruction; upstream holds Ins while high.
- Hi, Lo  out  32 each  — architectural registers, for debug and the testbench.

## Operation
- HI/LO instruction: Opcode == R_FORM and Funct ∈ {MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B}. Ins == 0 is a NOP and is never decoded.
- Acceptance:
  - An instruction is accepted only when Valid && !Stall.
  - All non-HI/LO instructions are ignored and never stalled.
- Reset: state = IDLE; Hi = Lo = 0; Busy = Stall = 0; all internal registers = 0.
- FSM states:
  - IDLE: on accepted MULT/MULTU/DIV/DIVU, latch operand magnitudes and the result signs, clear the counter, go to CALC. On accepted MTHI/MTLO, write Rdata1 into HI/LO at that edge and stay in IDLE.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. The counter runs 0..31; at count 31 go to FIX.
  - FIX: apply the sign correction, write HI/LO, go to IDLE.
- Signed operations (MULT, DIV) operate on magnitudes:
  - MULT: the 64-bit product is negated iff the operand signs differ.
  - DIV: the quotient is negated iff the signs differ; the remainder takes the sign of the dividend.
  - Unsigned operations skip all sign handling.
- Result placement:
  - Multiply: {HI, LO} = 64-bit product.
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (rt == 0), all variants: LO = 0xFFFFFFFF, HI = rs unchanged. No sign fix is applied.
- The most-negative operand (0x80000000) must be handled correctly; its magnitude is 33-bit-safe through the unsigned datapath.

## Timing
- Accept edge = E0. Busy goes high after E0. CALC occupies the edges E1..E32. FIX writes HI/LO at edge E33, and Busy drops after E33.
- A result is visible on Hi/Lo and HiLoOut in the cycle after E33. The next multiply/divide can be accepted at E34.
- MTHI/MTLO latency: one edge. MFHI/MFLO are combinational and accepted only when not Busy.
- While Busy, a HI/LO instruction raises Stall in the same cycle, combinationally.
- Simultaneous events: MFHI and MTHI cannot coincide, because there is one instruction per cycle.
- Asserting RST_N low mid-CALC aborts immediately to the reset values; the partial result is discarded.

## Structure
- Funct constants (MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU) and the state encodings (IDLE, CALC, FIX) are added to common_param.vh alongside R_FORM.
- Sub-module muldiv_core holds the shared 64-bit shift register, the 33-bit adder/subtractor and the counter. It takes start/op/operands and returns done/hi/lo.
- muldiv_unit holds the decode, the FSM, the sign fixup, the HI/LO registers and the Stall logic.

## Test plan
- MULTU, rs = rt = 0xFFFFFFFF → at E33: HI = 0xFFFFFFFE, LO = 0x00000001. Busy is high for exactly 33 cycles.
- MULT, rs = 0xFFFFFFFD (−3), rt = 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. MULT of 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV, −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU, 100 / 7 → LO = 14, HI = 2.
- DIVU 0x1234 / 0 → LO = 0xFFFFFFFF, HI = 0x1234.
- MFLO issued at E5 of a MULT → Stall high through E33. After release, HiLoOut equals the new LO. An ADDU issued mid-operation is never stalled.
- MTHI 0xCAFE while idle → HI = 0xCAFE after one edge. Drive RST_N low at E10 of a DIV → Busy = 0 and HI = LO = 0 immediately; a new MULT is accepted after RST_N deasserts.
